ro_mux_sched: RTL and testbench
===============================

# ro_mux_sched

Parametrised multi-channel readout scheduler, the successor to the fixed 2-bit, single-channel readout enable. It snapshots N_CH channel words of W bits at frame start. Each channel then drives a shared W-bit readout bus for SLOT_CYC clk_ext cycles, with a programmable guard interval of output-disable at the start of each slot. It sits between the per-channel output latches and the pad-level tri-state buffers, which consume `out` and `out_oe`.

## Interface
- N_CH, 4, number of channels; ≥1
- W, 2, bits per channel word; ≥1
- SLOT_CYC, 8, clk_ext cycles per channel slot (the former div-8 frame); ≥1
- GUARD, 1, cycles at the start of each slot with `out_oe` low; 0 ≤ GUARD < SLOT_CYC
- clk_ext  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  start request, sampled in IDLE and at frame end
- cont  in  1  1 = back-to-back frames while `en` is high; 0 = single shot
- in  in  N_CH*W  channel words; channel c occupies bits [c*W +: W]
- out  out  W  readout data, the snapshot word of the current channel
- out_oe  out  1  pad tri-state enable
- ch_idx  out  clog2(N_CH) (min 1)  channel currently in its slot
- frame_start  out  1  high on the first cycle of every frame
- done  out  1  high on the last cycle of every frame

## Operation
- States: IDLE, RUN. Registers: `state`, `ch`, `cnt` (slot cycle count, clog2(SLOT_CYC), min 1), `snap` (N_CH*W).
- Reset (`rst`=1 at an edge): state=IDLE, ch=0, cnt=0, snap=0. All outputs then read 0.
- IDLE, `en`=1 at an edge: snap←in, state←RUN, ch←0, cnt←0. `en`=0: remain in IDLE.
- RUN, each edge:
  - cnt<SLOT_CYC-1: cnt←cnt+1.
  - Otherwise cnt←0.
    - If ch<N_CH-1: ch←ch+1.
    - If ch==N_CH-1, the frame ends. If `cont`=1 and `en`=1: snap←in, ch←0, stay in RUN. Else state←IDLE, ch←0.
- Outputs are combinational from registers only, with no input-to-output paths:
  - out = snap[ch*W +: W] in RUN, else 0
  - out_oe = RUN && cnt ≥ GUARD
  - ch_idx = ch
  - frame_start = RUN && ch==0 && cnt==0
  - done = RUN && ch==N_CH-1 && cnt==SLOT_CYC-1
- Snapshot semantics: changes on `in` during a frame are invisible until the next snapshot.
- Deasserting `en` mid-frame does not abort. The frame completes, then the block returns to IDLE. Only `rst` aborts.
- The `cont` value used is the one sampled at the frame-end edge.

## Timing
- Start latency: `en` sampled at edge k. The frame occupies cycles k+1 … k+N_CH*SLOT_CYC, and frame_start is high in cycle k+1.
- Frame length is exactly N_CH*SLOT_CYC cycles.
- Continuous mode has zero idle cycles between frames. `done` and the next `frame_start` occur on consecutive cycles.
- Single shot: the block is in IDLE in the cycle after `done`. A new `en` is accepted at that cycle's closing edge, so the minimum gap is 1 idle cycle.
- Slot s of channel c: `out` is valid for all SLOT_CYC cycles. `out_oe` is low for the first GUARD cycles and high for SLOT_CYC-GUARD cycles.
- With SLOT_CYC=1, `cnt` is constant 0 and `ch` advances every cycle.
- `rst` takes priority over every transition, including the frame-end edge.

## Structure
- Package `ro_pkg`:
  - state enum {IDLE, RUN}
  - width helper function: clog2 with minimum 1
  - parameter-legality checks: GUARD<SLOT_CYC, N_CH≥1
- Sub-module `ro_slot_timer`: owns `cnt` and `ch`, takes `run` and `rst`, and emits `slot_last` and `frame_last`.
- The top level holds `state`, `snap` and the output decode.
- The tri-state pad drivers stay outside this block.

## Test plan
- Reset: hold rst for 3 cycles with en=1 -> out=0, out_oe=0, ch_idx=0, frame_start=0, done=0 throughout; a frame starts only after rst drops.
- Single shot, defaults: in=8'hE4, cont=0, 1-cycle en pulse -> out sequence 00, 01, 10, 11, each held for 8 cycles.
  - out_oe low on cycles 1, 9, 17, 25 of the frame.
  - frame_start at cycle 1, done at cycle 32, IDLE at cycle 33.
- Snapshot: same start, in changed to 8'h1B at frame cycle 5 -> full frame still reads 00, 01, 10, 11; next frame reads 11, 10, 01, 00.
- Continuous: cont=1, en held high for 100 cycles -> frame_start every 32 cycles with no gap; after en drops, the current frame finishes, done pulses, then IDLE.
- Abort: rst asserted at ch=2, cnt=3 -> next cycle all outputs 0, IDLE; a subsequent en starts a fresh frame at ch 0.
- Corner params N_CH=1, W=3, SLOT_CYC=1, GUARD=0, cont=1, en high -> out_oe=1 every cycle; frame_start=done=1 every cycle; out follows in with one cycle of latency.

Source files
------------

// File: rtl/ro_pkg.sv
// ro_pkg: shared types and elaboration helpers for the readout scheduler.
//   ro_state_e    - scheduler state (IDLE, RUN)
//   ro_clog2      - ceil(log2(v)), never less than 1, for register widths
//   ro_params_ok  - parameter legality check used at elaboration time
package ro_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ro_state_e;

    function automatic int unsigned ro_clog2(input int unsigned v);
        int unsigned r;
        r = (v <= 1) ? 1 : $clog2(v);
        return r;
    endfunction

    function automatic bit ro_params_ok(input int unsigned n_ch,
                                        input int unsigned w,
                                        input int unsigned slot_cyc,
                                        input int unsigned guard);
        return (n_ch >= 1) && (w >= 1) && (slot_cyc >= 1) && (guard < slot_cyc);
    endfunction

endpackage

// File: rtl/ro_slot_timer.sv
// ro_slot_timer: slot cycle counter and channel counter.
//   clk_ext     in   clock, rising edge
//   rst         in   synchronous active-high reset
//   run         in   advance counters this cycle (scheduler in RUN)
//   ch          out  current channel
//   cnt         out  cycle within the current slot
//   slot_last   out  cnt is at the last cycle of the slot
//   frame_last  out  last cycle of the last channel's slot
module ro_slot_timer
    import ro_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned SLOT_CYC = 8
) (
    input  logic                          clk_ext,
    input  logic                          rst,
    input  logic                          run,
    output logic [ro_clog2(N_CH)-1:0]     ch,
    output logic [ro_clog2(SLOT_CYC)-1:0] cnt,
    output logic                          slot_last,
    output logic                          frame_last
);

    localparam int unsigned CH_W  = ro_clog2(N_CH);
    localparam int unsigned CNT_W = ro_clog2(SLOT_CYC);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYC - 1);

    assign slot_last  = (cnt == CNT_LAST);
    assign frame_last = slot_last && (ch == CH_LAST);

    // Outside RUN both counters sit at 0, so a frame start needs no explicit clear.
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            ch  <= '0;
            cnt <= '0;
        end else if (run) begin
            if (slot_last) begin
                cnt <= '0;
                ch  <= frame_last ? '0 : ch + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ro_mux_sched.sv
// ro_mux_sched: multi-channel readout scheduler.
// Snapshots N_CH words of W bits at frame start, then drives each word onto
// the shared bus for SLOT_CYC cycles, with out_oe held low for the first
// GUARD cycles of every slot.
//   clk_ext      in   clock, rising edge
//   rst          in   synchronous active-high reset
//   en           in   start request (sampled in IDLE and at frame end)
//   cont         in   1 = back-to-back frames while en is high
//   in           in   channel words, channel c at [c*W +: W]
//   out          out  snapshot word of the current channel (0 when idle)
//   out_oe       out  pad tri-state enable
//   ch_idx       out  channel currently in its slot
//   frame_start  out  first cycle of a frame
//   done         out  last cycle of a frame
module ro_mux_sched
    import ro_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned W        = 2,
    parameter int unsigned SLOT_CYC = 8,
    parameter int unsigned GUARD    = 1
) (
    input  logic                      clk_ext,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      cont,
    input  logic [N_CH*W-1:0]         in,
    output logic [W-1:0]              out,
    output logic                      out_oe,
    output logic [ro_clog2(N_CH)-1:0] ch_idx,
    output logic                      frame_start,
    output logic                      done
);

    localparam int unsigned CH_W  = ro_clog2(N_CH);
    localparam int unsigned CNT_W = ro_clog2(SLOT_CYC);

    if (!ro_params_ok(N_CH, W, SLOT_CYC, GUARD)) begin : g_bad_params
        $error("ro_mux_sched: illegal parameters (need N_CH>=1, W>=1, SLOT_CYC>=1, GUARD<SLOT_CYC)");
    end

    ro_state_e          state, state_nxt;
    logic [N_CH*W-1:0]  snap;
    logic               snap_load;
    logic [CH_W-1:0]    ch;
    logic [CNT_W-1:0]   cnt;
    logic               slot_last;
    logic               frame_last;
    logic               running;
    logic               guard_ok;
    logic [W-1:0]       word;

    assign running = (state == RUN);

    ro_slot_timer #(
        .N_CH     (N_CH),
        .SLOT_CYC (SLOT_CYC)
    ) u_timer (
        .clk_ext    (clk_ext),
        .rst        (rst),
        .run        (running),
        .ch         (ch),
        .cnt        (cnt),
        .slot_last  (slot_last),
        .frame_last (frame_last)
    );

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        snap_load = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                    snap_load = 1'b1;
                end
            end
            RUN: begin
                if (frame_last) begin
                    if (cont && en) begin
                        snap_load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            snap <= '0;
        end else if (snap_load) begin
            snap <= in;
        end
    end

    // Compare-select mux keeps the index arithmetic at constant widths.
    always_comb begin
        word = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (ch == CH_W'(c)) begin
                word = snap[c*W +: W];
            end
        end
    end

    if (GUARD == 0) begin : g_no_guard
        assign guard_ok = 1'b1;
    end else begin : g_guard
        assign guard_ok = (cnt >= CNT_W'(GUARD));
    end

    assign out         = running ? word : '0;
    assign out_oe      = running && guard_ok;
    assign ch_idx      = ch;
    assign frame_start = running && (ch == '0) && (cnt == '0);
    assign done        = running && frame_last;

    logic unused_slot_last;
    assign unused_slot_last = slot_last;

endmodule

// File: tb/tb_ro_mux_sched.sv
module tb_ro_mux_sched;

    logic       clk_ext = 1'b0;
    logic       rst;
    logic       en, cont;
    logic [7:0] in;
    logic [1:0] out;
    logic       out_oe;
    logic [1:0] ch_idx;
    logic       frame_start, done;

    logic       en2, cont2;
    logic [2:0] in2;
    logic [2:0] out2;
    logic       out_oe2;
    logic [0:0] ch_idx2;
    logic       frame_start2, done2;

    int checks   = 0;
    int failures = 0;

    always #5 clk_ext = ~clk_ext;

    ro_mux_sched #(
        .N_CH     (4),
        .W        (2),
        .SLOT_CYC (8),
        .GUARD    (1)
    ) dut (
        .clk_ext     (clk_ext),
        .rst         (rst),
        .en          (en),
        .cont        (cont),
        .in          (in),
        .out         (out),
        .out_oe      (out_oe),
        .ch_idx      (ch_idx),
        .frame_start (frame_start),
        .done        (done)
    );

    ro_mux_sched #(
        .N_CH     (1),
        .W        (3),
        .SLOT_CYC (1),
        .GUARD    (0)
    ) dut_corner (
        .clk_ext     (clk_ext),
        .rst         (rst),
        .en          (en2),
        .cont        (cont2),
        .in          (in2),
        .out         (out2),
        .out_oe      (out_oe2),
        .ch_idx      (ch_idx2),
        .frame_start (frame_start2),
        .done        (done2)
    );

    // Observation vector: {out[1:0], out_oe, ch_idx[1:0], frame_start, done}
    function automatic logic [6:0] obs();
        return {out, out_oe, ch_idx, frame_start, done};
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; cont = 1'b0; in = 8'hE4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_ext);
            checks++;
            if (obs() !== 7'h00) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h want=00", i, obs());
            end
        end
        rst = 1'b0;
        @(negedge clk_ext);
        checks++;
        // first cycle after release: frame_start, ch0 word 00, guard cycle
        if (obs() !== 7'b00_0_00_1_0) begin
            failures++;
            $display("FAIL reset_release got=%h want=%h", obs(), 7'b00_0_00_1_0);
        end
        en  = 1'b0;
        rst = 1'b1;
        @(negedge clk_ext);
        rst = 1'b0;
    endtask

    task automatic test_single_shot();
        logic [1:0] words [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [6:0] exp;
        int c, k;
        cont = 1'b0; in = 8'hE4; en = 1'b1;
        @(negedge clk_ext);
        en = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            c = (i - 1) / 8;
            k = (i - 1) % 8;
            exp = {words[c], (k >= 1), 2'(c), (i == 1), (i == 32)};
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL single_shot cyc=%0d got=%h want=%h", i, obs(), exp);
            end
            @(negedge clk_ext);
        end
        checks++;
        if (obs() !== 7'h00) begin
            failures++;
            $display("FAIL single_shot_idle got=%h want=00", obs());
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] snapv;
        logic [1:0] w;
        logic [6:0] exp;
        int f, j, c, k;
        cont = 1'b1; in = 8'hE4; en = 1'b1;
        @(negedge clk_ext);
        for (int i = 1; i <= 64; i++) begin
            f = (i - 1) / 32;
            j = (i - 1) % 32;
            c = j / 8;
            k = j % 8;
            snapv = (f == 0) ? 8'hE4 : 8'h1B;
            w = snapv[2*c +: 2];
            exp = {w, (k >= 1), 2'(c), (j == 0), (j == 31)};
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL snapshot cyc=%0d got=%h want=%h", i, obs(), exp);
            end
            if (i == 5)  in = 8'h1B;
            if (i == 33) en = 1'b0;
            if (i == 36) in = 8'hE4;
            @(negedge clk_ext);
        end
        checks++;
        if (obs() !== 7'h00) begin
            failures++;
            $display("FAIL snapshot_idle got=%h want=00", obs());
        end
        cont = 1'b0;
    endtask

    task automatic test_continuous();
        logic [3:0] got, exp;
        int j;
        cont = 1'b1; in = 8'h9C; en = 1'b1;
        @(negedge clk_ext);
        for (int i = 1; i <= 129; i++) begin
            j = (i - 1) % 32;
            got = {frame_start, done, ch_idx};
            if (i <= 128) exp = {(j == 0), (j == 31), 2'(j / 8)};
            else          exp = 4'h0;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL continuous cyc=%0d got=%h want=%h", i, got, exp);
            end
            if (i == 100) en = 1'b0;
            @(negedge clk_ext);
        end
        checks++;
        if (obs() !== 7'h00) begin
            failures++;
            $display("FAIL continuous_idle got=%h want=00", obs());
        end
        cont = 1'b0;
    endtask

    task automatic test_abort();
        cont = 1'b1; in = 8'h4E; en = 1'b1;
        @(negedge clk_ext);
        for (int i = 1; i < 20; i++) @(negedge clk_ext);
        // cycle 20: ch=2, cnt=3; 8'h4E ch2 word = 2'b00, ch0 word = 2'b10
        checks++;
        if (obs() !== 7'b00_1_10_0_0) begin
            failures++;
            $display("FAIL abort_pre got=%h want=%h", obs(), 7'b00_1_10_0_0);
        end
        rst = 1'b1;
        @(negedge clk_ext);
        checks++;
        if (obs() !== 7'h00) begin
            failures++;
            $display("FAIL abort_reset got=%h want=00", obs());
        end
        rst = 1'b0; en = 1'b0; cont = 1'b0;
        @(negedge clk_ext);
        checks++;
        if (obs() !== 7'h00) begin
            failures++;
            $display("FAIL abort_idle got=%h want=00", obs());
        end
        en = 1'b1;
        @(negedge clk_ext);
        en = 1'b0;
        checks++;
        if (obs() !== 7'b10_0_00_1_0) begin
            failures++;
            $display("FAIL abort_restart got=%h want=%h", obs(), 7'b10_0_00_1_0);
        end
        @(negedge clk_ext);
        checks++;
        if (obs() !== 7'b10_1_00_0_0) begin
            failures++;
            $display("FAIL abort_restart_oe got=%h want=%h", obs(), 7'b10_1_00_0_0);
        end
        rst = 1'b1;
        @(negedge clk_ext);
        rst = 1'b0;
    endtask

    task automatic test_corner();
        logic [2:0] vals [5] = '{3'h5, 3'h2, 3'h7, 3'h0, 3'h6};
        logic [5:0] got, exp;
        cont2 = 1'b1; en2 = 1'b1; in2 = vals[0];
        @(negedge clk_ext);
        for (int k = 1; k <= 5; k++) begin
            got = {out2, out_oe2, ch_idx2, frame_start2, done2};
            exp = {vals[k-1], 1'b1, 1'b0, 1'b1, 1'b1};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL corner cyc=%0d got=%h want=%h", k, got, exp);
            end
            if (k < 5) in2 = vals[k];
            else       en2 = 1'b0;
            @(negedge clk_ext);
        end
        got = {out2, out_oe2, ch_idx2, frame_start2, done2};
        checks++;
        if (got !== 6'h00) begin
            failures++;
            $display("FAIL corner_idle got=%h want=00", got);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cont = 1'b0; in = '0;
        en2 = 1'b0; cont2 = 1'b0; in2 = '0;
        test_reset();
        test_single_shot();
        test_snapshot();
        test_continuous();
        test_abort();
        test_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
